// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit frame path.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_serializer.sv
// Payload shift register with bit counter; ser_data_o is the bit the line carries next,
// ser_done_o flags the last payload bit.
module tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ser_data_o,
    output logic                  ser_done_o
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = data_i;
            cnt_d = '0;
        end else if (shift_i) begin
            sh_d  = {1'b0, sh_q[DATA_WIDTH-1:1]};
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Post-shift LSB, so the registered line output lines up with the counter.
    assign ser_data_o = sh_d[0];
    assign ser_done_o = shift_i && !load_i && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first payload, optional parity, stop; one bit per clk.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_t state_q, state_d;
    logic      tx_d, busy_d;
    logic      load, shift, ser_data, ser_done;
    logic      par_bit, par_on;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d, par_en_q, par_en_d;

    always_comb begin
        par_d    = par_q;
        par_en_d = par_en_q;
        if (load) begin
            par_en_d = PAR_EN;
            par_d    = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            par_q    <= par_d;
            par_en_q <= par_en_d;
        end
    end

    assign par_bit = par_q;
    assign par_on  = par_en_q;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
    assign par_bit    = LINE_IDLE;
    assign par_on     = 1'b0;
`endif

    tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .shift_i    (shift),
        .data_i     (P_DATA),
        .ser_data_o (ser_data),
        .ser_done_o (ser_done)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START:  state_d = DATA;
            DATA: begin
                shift = 1'b1;
                if (ser_done) state_d = par_on ? PARITY : STOP;
            end
            PARITY: state_d = STOP;
            STOP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line and busy are registered from the next state so they change on the same edge.
    always_comb begin
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = ser_data;
            PARITY:  tx_d = par_bit;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = LINE_IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            TX_OUT  <= LINE_IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame; expectations adapt to whether UART_TX_PARITY_EN is defined.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
    localparam bit HasPar = 1'b1;
`else
    localparam bit HasPar = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       exp_par;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line sequence in transmit order: start, data LSB first, [parity], stop.
    task automatic build(input logic [7:0] d, input logic pe, input logic ep,
                         output logic [11:0] bits, output int len);
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pe && HasPar) begin
            bits[9]  = ep;
            bits[10] = 1'b1;
            len      = 11;
        end else begin
            bits[9] = 1'b1;
            len     = 10;
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input logic ep);
        logic [11:0] bits;
        int          len;
        int          nb;
        build(d, pe, ep, bits, len);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        nb = 0;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s_bit%0d", name, i), 32'(TX_OUT), 32'(bits[i]));
            if (busy) nb++;
            tick();
        end
        chk({name, "_busy_cycles"}, nb, len);
        chk({name, "_idle_line"}, 32'(TX_OUT), 32'd1);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] bits, bits2;
        int          len, len2;
        logic [9:0]  got;

        vecs[0] = '{"a5_even", 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"01_odd",  8'h01, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{"01_even", 8'h01, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"ff_odd",  8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{"80_even", 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{"00_odd",  8'h00, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{"c3_nopar", 8'hC3, 1'b0, 1'b1, 1'b0};

        rst_n      = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        tick();
        tick();
        chk("reset_tx", 32'(TX_OUT), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_tx", 32'(TX_OUT), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Explicit 0xA5 frame without parity, captured then compared as a whole.
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        len = 0;
        for (int i = 0; i < 10; i++) begin
            got[i] = TX_OUT;
            if (busy) len++;
            tick();
        end
        chk("a5_frame", 32'(got), 32'(10'b1101001010));
        chk("a5_busy_cycles", len, 10);
        chk("a5_busy_fall", 32'(busy), 32'd0);

        foreach (vecs[v])
            run_frame(vecs[v].name, vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].exp_par);

        // Request and input changes during a frame must be ignored.
        build(8'h3C, 1'b0, 1'b0, bits, len);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("ign_bit%0d", i), 32'(TX_OUT), 32'(bits[i]));
            if (i == 4) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
                PAR_EN     = 1'b1;
                PAR_TYP    = 1'b1;
            end else begin
                Data_Valid = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ign_idle_tx%0d", i), 32'(TX_OUT), 32'd1);
            chk($sformatf("ign_idle_busy%0d", i), 32'(busy), 32'd0);
            tick();
        end
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;

        // Reset during data bit 5 with a simultaneous request.
        P_DATA     = 8'h0F;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_pre_bit5", 32'(TX_OUT), 32'd0);
        rst_n      = 1'b0;
        Data_Valid = 1'b1;
        P_DATA     = 8'hAA;
        tick();
        chk("rst_tx", 32'(TX_OUT), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n      = 1'b1;
        Data_Valid = 1'b0;
        tick();
        chk("rst_drop_busy", 32'(busy), 32'd0);
        chk("rst_drop_tx", 32'(TX_OUT), 32'd1);
        run_frame("rst_55", 8'h55, 1'b0, 1'b0, 1'b0);

        // Data_Valid held: two frames with exactly one idle-high cycle between.
        build(8'h12, 1'b1, 1'b0, bits, len);
        build(8'h34, 1'b1, 1'b1, bits2, len2);
        P_DATA     = 8'h12;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        tick();
        P_DATA = 8'h34;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("b2b1_bit%0d", i), 32'(TX_OUT), 32'(bits[i]));
            chk($sformatf("b2b1_busy%0d", i), 32'(busy), 32'd1);
            tick();
        end
        chk("b2b_gap_tx", 32'(TX_OUT), 32'd1);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < len2; i++) begin
            chk($sformatf("b2b2_bit%0d", i), 32'(TX_OUT), 32'(bits2[i]));
            chk($sformatf("b2b2_busy%0d", i), 32'(busy), 32'd1);
            tick();
        end
        chk("b2b_end_tx", 32'(TX_OUT), 32'd1);
        chk("b2b_end_busy", 32'(busy), 32'd0);
        tick();
        chk("b2b_no_third", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
